// File: rtl/uart_debug_loader.sv
`default_nettype none
// ============================================================================
// Module      : uart_debug_loader
// Description : UART (8N1) receiver feeding a word loader that writes a
//               length-prefixed, little-endian image into an instruction ROM
//               while uart_debug_pin is held high.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_debug_loader #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200,
  parameter int ADDR_W   = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_debug_pin,
  input  logic              uart_rx,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              load_busy,
  output logic              load_done,
  output logic              frame_err
);

  localparam int DIV  = CLK_FREQ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV + 1);
  localparam logic [CW-1:0] c_bit_last  = CW'(DIV - 1);
  localparam logic [CW-1:0] c_half_last = CW'(HALF - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {IDLE, LEN, DATA, DONE} ld_state_t;

  logic          r_rx_s1, r_rx_s2;
  rx_state_t     r_rx_state, w_rx_next;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_shift;
  logic          r_byte_valid;
  logic          r_byte_ok;

  ld_state_t         r_ld_state, w_ld_next;
  logic              r_pin_q;
  logic [1:0]        r_bidx;
  logic [31:0]       r_asm;
  logic [31:0]       r_words;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_frame_err;

  logic        w_bit_tick, w_half_tick, w_frame_bad;
  logic        w_rise, w_load_active, w_take;
  logic [31:0] w_word;

  assign w_bit_tick    = (r_rx_cnt == c_bit_last);
  assign w_half_tick   = (r_rx_cnt == c_half_last);
  assign w_frame_bad   = (r_rx_state == RX_STOP) && w_bit_tick && !r_rx_s2;
  assign w_rise        = uart_debug_pin && !r_pin_q;
  assign w_load_active = (r_ld_state == LEN) || (r_ld_state == DATA);
  // A byte is only consumed if its start bit began inside the load window
  // and the enable is still high in the same cycle.
  assign w_take        = r_byte_valid && r_byte_ok && uart_debug_pin && w_load_active;
  assign w_word        = {r_rx_shift, r_asm[31:8]};

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign load_busy = w_load_active;
  assign load_done = (r_ld_state == DONE);
  assign frame_err = r_frame_err;

  // Two-flop synchronizer for the asynchronous serial line, idling high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= uart_rx;
      r_rx_s2 <= r_rx_s1;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rx_state <= RX_IDLE;
    else     r_rx_state <= w_rx_next;
  end

  // Receiver next state: mid-start check rejects short glitches.
  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE:  if (!r_rx_s2) w_rx_next = RX_START;
      RX_START: if (w_half_tick) w_rx_next = r_rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_bit_tick && (r_rx_bit == 3'd7)) w_rx_next = RX_STOP;
      RX_STOP:  if (w_bit_tick) w_rx_next = RX_IDLE;
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  // Receiver datapath: bit timer, LSB-first shifter and byte strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_cnt     <= '0;
      r_rx_bit     <= '0;
      r_rx_shift   <= '0;
      r_byte_valid <= 1'b0;
      r_byte_ok    <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      if ((r_rx_state == RX_IDLE) && !r_rx_s2) r_byte_ok <= w_load_active || w_rise;
      else if (w_rise)                          r_byte_ok <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          r_rx_cnt <= '0;
          r_rx_bit <= '0;
        end
        RX_START: r_rx_cnt <= w_half_tick ? '0 : r_rx_cnt + CW'(1);
        RX_DATA: begin
          if (w_bit_tick) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 3'd1;
          end else begin
            r_rx_cnt <= r_rx_cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (w_bit_tick) begin
            r_rx_cnt <= '0;
            if (r_rx_s2) r_byte_valid <= 1'b1;
          end else begin
            r_rx_cnt <= r_rx_cnt + CW'(1);
          end
        end
        default: r_rx_cnt <= '0;
      endcase
    end
  end

  // Loader state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ld_state <= IDLE;
    else     r_ld_state <= w_ld_next;
  end

  // Loader next state: enable fall aborts, length then data words.
  always_comb begin
    w_ld_next = r_ld_state;
    case (r_ld_state)
      IDLE: if (w_rise) w_ld_next = LEN;
      LEN: begin
        if (!uart_debug_pin)                  w_ld_next = IDLE;
        else if (w_take && (r_bidx == 2'd3)) w_ld_next = (w_word == 32'd0) ? DONE : DATA;
      end
      DATA: begin
        if (!uart_debug_pin)                                          w_ld_next = IDLE;
        else if (w_take && (r_bidx == 2'd3) && (r_words == 32'd1)) w_ld_next = DONE;
      end
      DONE:    w_ld_next = IDLE;
      default: w_ld_next = IDLE;
    endcase
  end

  // Loader datapath: word assembly, write strobe, address and error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pin_q     <= 1'b1;  // a pin already high at release is not an edge
      r_bidx      <= '0;
      r_asm       <= '0;
      r_words     <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_pin_q  <= uart_debug_pin;
      r_mem_we <= 1'b0;
      if (w_frame_bad) r_frame_err <= 1'b1;
      if (r_mem_we)    r_mem_addr  <= r_mem_addr + ADDR_W'(1);
      if ((r_ld_state == IDLE) && w_rise) begin
        r_bidx      <= '0;
        r_asm       <= '0;
        r_words     <= '0;
        r_mem_addr  <= '0;
        r_frame_err <= 1'b0;
      end else if (w_load_active && !uart_debug_pin) begin
        r_bidx <= '0;
      end else if (w_take) begin
        if (r_bidx == 2'd3) begin
          r_bidx <= '0;
          if (r_ld_state == LEN) begin
            r_words <= w_word;
          end else begin
            r_mem_wdata <= w_word;
            r_mem_we    <= 1'b1;
            r_words     <= r_words - 32'd1;
          end
        end else begin
          r_bidx <= r_bidx + 2'd1;
          r_asm  <= w_word;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_debug_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_debug_loader
// Description : Scoreboard bench for uart_debug_loader: directed scenarios
//               plus randomized loads against a byte-stream reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_debug_loader;

  // Short bit period and a small ROM keep the run short and exercise wrap.
  localparam int CLK_FREQ = 1200000;
  localparam int BAUD     = 100000;
  localparam int ADDR_W   = 2;
  localparam int DIV      = CLK_FREQ / BAUD;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              pin = 1'b0;
  logic              rx  = 1'b1;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy, done, ferr;

  uart_debug_loader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .uart_debug_pin(pin), .uart_rx(rx),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .load_busy(busy), .load_done(done), .frame_err(ferr)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [ADDR_W-1:0] addr; logic [31:0] data; } wr_t;
  typedef struct packed { logic [7:0] data; logic good; } byte_t;

  wr_t   exp_q[$];
  byte_t load_q[$];
  wr_t   m_e;
  int    vectors = 0, miscompares = 0, done_seen = 0;
  int    exp_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: addr %0d data 0x%08h with no write expected", mem_addr, mem_wdata);
        end else begin
          m_e = exp_q.pop_front();
          check("write_addr", 64'(mem_addr), 64'(m_e.addr));
          check("write_data", 64'(mem_wdata), 64'(m_e.data));
        end
      end
      if (done) done_seen++;
    end
  end

  // Reference model: keep good bytes only, first four are the length,
  // then whole words up to that length; addresses count from zero.
  task automatic model(input int sent);
    logic [7:0] g[$];
    longint n, avail, w;
    for (int i = 0; i < load_q.size(); i++)
      if (i < sent && load_q[i].good) g.push_back(load_q[i].data);
    exp_done = 0;
    if (g.size() < 4) return;
    n     = longint'({g[3], g[2], g[1], g[0]});
    avail = longint'((g.size() - 4) / 4);
    w     = (n < avail) ? n : avail;
    for (int k = 0; k < int'(w); k++)
      exp_q.push_back('{addr: ADDR_W'(k), data: {g[4*k+7], g[4*k+6], g[4*k+5], g[4*k+4]}});
    exp_done = (avail >= n) ? 1 : 0;
  endtask

  task automatic push_byte(input logic [7:0] d, input logic good);
    load_q.push_back('{data: d, good: good});
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) push_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic good);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (DIV) @(negedge clk);
    end
    rx = good;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
    repeat (2 * DIV) @(negedge clk);
  endtask

  task automatic glitch(input int len);
    rx = 1'b0;
    repeat (len) @(negedge clk);
    rx = 1'b1;
    repeat (2 * DIV) @(negedge clk);
  endtask

  // One load: enable rise, optional glitch, bytes, optional abort, checks.
  task automatic run_load(input int abort_after, input bit with_glitch, input string tag);
    int base;
    pin = 1'b0;
    repeat (3) @(negedge clk);
    pin = 1'b1;
    repeat (3) @(negedge clk);
    check({tag, "_busy_start"}, 64'(busy), 64'd1);
    check({tag, "_ferr_cleared"}, 64'(ferr), 64'd0);
    base = done_seen;
    model(abort_after < 0 ? load_q.size() : abort_after);
    if (with_glitch) glitch(DIV / 3);
    for (int i = 0; i < load_q.size(); i++) begin
      if (abort_after >= 0 && i == abort_after) break;
      send_byte(load_q[i].data, load_q[i].good);
    end
    if (abort_after >= 0) begin
      pin = 1'b0;
      @(negedge clk);
      check({tag, "_abort_busy"}, 64'(busy), 64'd0);
    end
    repeat (4 * DIV) @(negedge clk);
    check({tag, "_done_count"}, 64'(done_seen - base), 64'(exp_done));
    check({tag, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
    if (abort_after < 0 && exp_done == 1) check({tag, "_busy_end"}, 64'(busy), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ab, pos;
    byte_t tmp;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_we",    64'(mem_we),    64'd0);
    check("rst_addr",  64'(mem_addr),  64'd0);
    check("rst_wdata", 64'(mem_wdata), 64'd0);
    check("rst_busy",  64'(busy),      64'd0);
    check("rst_done",  64'(done),      64'd0);
    check("rst_ferr",  64'(ferr),      64'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Normal two-word load.
    load_q.delete();
    push_word(32'd2); push_word(32'h13); push_word(32'h6F);
    run_load(-1, 1'b0, "normal");
    check("normal_addr_after", 64'(mem_addr), 64'd2);
    check("normal_wdata_hold", 64'(mem_wdata), 64'h6F);

    // Zero length.
    load_q.delete();
    push_word(32'd0);
    run_load(-1, 1'b0, "zero");
    check("zero_addr", 64'(mem_addr), 64'd0);

    // Framing error on second data byte.
    load_q.delete();
    push_word(32'd1);
    push_byte(8'hA1, 1'b1); push_byte(8'hB2, 1'b0);
    push_byte(8'hC3, 1'b1); push_byte(8'hD4, 1'b1); push_byte(8'hE5, 1'b1);
    push_byte(8'hF6, 1'b1); push_byte(8'h07, 1'b1);
    run_load(-1, 1'b0, "frame");
    check("frame_err_set", 64'(ferr), 64'd1);

    // Glitch before the length bytes must not shift byte alignment.
    load_q.delete();
    push_word(32'd1); push_word(32'hCAFEF00D);
    run_load(-1, 1'b1, "glitch");

    // Abort after six data bytes of a four-word load.
    load_q.delete();
    push_word(32'd4);
    for (int i = 0; i < 4; i++) push_word($urandom);
    run_load(10, 1'b0, "abort");

    // Randomized loads, with wrap, framing errors and aborts.
    for (int it = 0; it < 6; it++) begin
      load_q.delete();
      n = $urandom_range(0, 5);
      push_word(32'(n));
      for (int i = 0; i < n; i++) push_word($urandom);
      if ($urandom_range(0, 3) == 0) begin
        pos = $urandom_range(0, load_q.size());
        tmp = '{data: 8'($urandom), good: 1'b0};
        load_q.insert(pos, tmp);
      end
      if ($urandom_range(0, 2) == 0) push_byte(8'($urandom), 1'b1);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, load_q.size() - 1) : -1;
      run_load(ab, 1'b0, "random");
    end

    // Asynchronous reset in the middle of a data byte.
    load_q.delete();
    push_word(32'd4);
    for (int i = 0; i < 4; i++) push_word($urandom | 32'h1);
    pin = 1'b0;
    repeat (3) @(negedge clk);
    pin = 1'b1;
    repeat (3) @(negedge clk);
    model(10);
    for (int i = 0; i < 10; i++) send_byte(load_q[i].data, load_q[i].good);
    check("pre_reset_pending", 64'(exp_q.size()), 64'd0);
    rx = 1'b0;
    repeat (3 * DIV) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_we",    64'(mem_we),    64'd0);
    check("mid_rst_addr",  64'(mem_addr),  64'd0);
    check("mid_rst_wdata", 64'(mem_wdata), 64'd0);
    check("mid_rst_busy",  64'(busy),      64'd0);
    check("mid_rst_done",  64'(done),      64'd0);
    check("mid_rst_ferr",  64'(ferr),      64'd0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    begin
      int base;
      base = done_seen;
      load_q.delete();
      push_word(32'd1); push_word(32'h12345678);
      for (int i = 0; i < load_q.size(); i++) send_byte(load_q[i].data, load_q[i].good);
      repeat (4 * DIV) @(negedge clk);
      check("post_rst_no_done", 64'(done_seen - base), 64'd0);
      check("post_rst_busy",    64'(busy),             64'd0);
    end
    run_load(-1, 1'b0, "post_rst_toggle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
